// File: rtl/mac_thread_if.sv
// Operand-beat, control and result bundle for one mac_thread.
// master drives commands and operands; slave is the thread itself.
interface mac_thread_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 20,
   parameter int K_MAX      = 16
);
   localparam int KW = $clog2(K_MAX + 1);

   logic                  start;
   logic [KW-1:0]         k_len;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] a;
   logic [DATA_WIDTH-1:0] b;
   logic [ACC_WIDTH-1:0]  res;
   logic                  res_valid;
   logic                  res_ready;
   logic                  busy;
   logic                  sat;

   modport master (
      output start, k_len, in_valid, a, b, res_ready,
      input  in_ready, res, res_valid, busy, sat
   );

   modport slave (
      input  start, k_len, in_valid, a, b, res_ready,
      output in_ready, res, res_valid, busy, sat
   );
endinterface

// File: rtl/mac_thread.sv
// Multiply-accumulate thread: one dot-product element, handshaked beats in, held result out.
// Define MAC_THREAD_SAT_EN for saturating accumulation with a sticky sat flag (default wraps).
module mac_thread #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 20,
   parameter int K_MAX      = 16,
   parameter bit SIGNED     = 1'b0
) (
   input logic         clk,
   input logic         rst,
   mac_thread_if.slave bus
);
   localparam int KW = $clog2(K_MAX + 1);
   localparam int PW = 2 * DATA_WIDTH;

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t               state;
   state_t               state_nxt;
   logic [KW-1:0]        klen_q;
   logic [KW-1:0]        cnt;
   logic [KW-1:0]        k_clamped;
   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH-1:0] res_q;
   logic [ACC_WIDTH-1:0] p_ext;
   logic [ACC_WIDTH-1:0] add_res;
   logic [PW-1:0]        a_ext;
   logic [PW-1:0]        b_ext;
   logic [PW-1:0]        prod;
   logic                 beat;
   logic                 last_beat;
   logic                 add_ovf;

   assign k_clamped = (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;
   assign beat      = bus.in_valid && (state == ACCUM);
   assign last_beat = (cnt == klen_q - KW'(1));

   // Operands are extended to the full product width first so the low PW bits
   // of the multiply are the exact product in either signedness.
   always_comb begin
      if (SIGNED) begin
         a_ext = PW'($signed(bus.a));
         b_ext = PW'($signed(bus.b));
      end else begin
         a_ext = PW'(bus.a);
         b_ext = PW'(bus.b);
      end
      prod = a_ext * b_ext;
      if (SIGNED) begin
         p_ext = ACC_WIDTH'($signed(prod));
      end else begin
         p_ext = ACC_WIDTH'(prod);
      end
   end

`ifdef MAC_THREAD_SAT_EN
   logic [ACC_WIDTH:0]   sum_w;
   logic [ACC_WIDTH-1:0] sum;
   logic                 sat_q;

   always_comb begin
      sum_w   = {1'b0, acc} + {1'b0, p_ext};
      sum     = sum_w[ACC_WIDTH-1:0];
      add_ovf = 1'b0;
      add_res = sum;
      if (SIGNED) begin
         add_ovf = (acc[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) &&
                   (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
         if (add_ovf) begin
            add_res = p_ext[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
         end
      end else begin
         add_ovf = sum_w[ACC_WIDTH];
         if (add_ovf) begin
            add_res = {ACC_WIDTH{1'b1}};
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sat_q <= 1'b0;
      end else if (state == IDLE && bus.start) begin
         sat_q <= 1'b0;
      end else if (beat && add_ovf) begin
         sat_q <= 1'b1;
      end
   end

   assign bus.sat = sat_q;
`else
   assign add_res = acc + p_ext;
   assign add_ovf = 1'b0;
   assign bus.sat = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = (k_clamped == '0) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (beat && last_beat) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (bus.res_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         klen_q <= '0;
         cnt    <= '0;
         acc    <= '0;
         res_q  <= '0;
      end else begin
         if (state == IDLE && bus.start) begin
            klen_q <= k_clamped;
            cnt    <= '0;
            acc    <= '0;
            if (k_clamped == '0) begin
               res_q <= '0;
            end
         end else if (beat) begin
            acc <= add_res;
            cnt <= cnt + KW'(1);
            if (last_beat) begin
               res_q <= add_res;
            end
         end
      end
   end

   assign bus.in_ready  = (state == ACCUM);
   assign bus.busy      = (state != IDLE);
   assign bus.res_valid = (state == DONE);
   assign bus.res       = res_q;
endmodule

// File: tb/tb_mac_thread.sv
// Directed bench for mac_thread: unsigned 20-bit, unsigned 16-bit and signed 20-bit instances.
module tb_mac_thread;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   n;

   always #5 clk = ~clk;

   mac_thread_if #(.DATA_WIDTH(8), .ACC_WIDTH(20), .K_MAX(16)) bus0();
   mac_thread_if #(.DATA_WIDTH(8), .ACC_WIDTH(16), .K_MAX(16)) bus1();
   mac_thread_if #(.DATA_WIDTH(8), .ACC_WIDTH(20), .K_MAX(16)) bus2();

   mac_thread #(.DATA_WIDTH(8), .ACC_WIDTH(20), .K_MAX(16), .SIGNED(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .bus(bus0.slave));
   mac_thread #(.DATA_WIDTH(8), .ACC_WIDTH(16), .K_MAX(16), .SIGNED(1'b0)) u_dut1 (
      .clk(clk), .rst(rst), .bus(bus1.slave));
   mac_thread #(.DATA_WIDTH(8), .ACC_WIDTH(20), .K_MAX(16), .SIGNED(1'b1)) u_dut2 (
      .clk(clk), .rst(rst), .bus(bus2.slave));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      {bus0.start, bus0.k_len, bus0.in_valid, bus0.a, bus0.b, bus0.res_ready} = '0;
      {bus1.start, bus1.k_len, bus1.in_valid, bus1.a, bus1.b, bus1.res_ready} = '0;
      {bus2.start, bus2.k_len, bus2.in_valid, bus2.a, bus2.b, bus2.res_ready} = '0;
      step();
      step();
      check("rst_res", 32'(bus0.res), 0);
      check("rst_res_valid", 32'(bus0.res_valid), 0);
      check("rst_in_ready", 32'(bus0.in_ready), 0);
      check("rst_busy", 32'(bus0.busy), 0);
      check("rst_sat", 32'(bus0.sat), 0);
      rst = 1'b1;
      step();

      // basic unsigned dot product 1*4 + 2*5 + 3*6
      bus0.start = 1'b1; bus0.k_len = 5'd3;
      step();
      bus0.start = 1'b0;
      check("t1_in_ready", 32'(bus0.in_ready), 1);
      check("t1_busy", 32'(bus0.busy), 1);
      bus0.in_valid = 1'b1; bus0.a = 8'd1; bus0.b = 8'd4;
      step();
      bus0.a = 8'd2; bus0.b = 8'd5;
      step();
      bus0.a = 8'd3; bus0.b = 8'd6;
      step();
      bus0.in_valid = 1'b0;
      check("t1_res_valid", 32'(bus0.res_valid), 1);
      check("t1_res", 32'(bus0.res), 32);
      bus0.res_ready = 1'b1;
      step();
      check("t1_handoff_valid", 32'(bus0.res_valid), 0);
      check("t1_res_kept", 32'(bus0.res), 32);
      check("t1_idle", 32'(bus0.busy), 0);

      // same product with input gaps, then a stalled consumer
      bus0.res_ready = 1'b0;
      bus0.start = 1'b1; bus0.k_len = 5'd3;
      step();
      bus0.start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus0.in_valid = (i % 2 == 0);
         case (i / 2)
            0: begin bus0.a = 8'd1; bus0.b = 8'd4; end
            1: begin bus0.a = 8'd2; bus0.b = 8'd5; end
            default: begin bus0.a = 8'd3; bus0.b = 8'd6; end
         endcase
         if (i % 2 == 1) begin
            bus0.a = 8'hFF; bus0.b = 8'hFF;
         end
         step();
      end
      bus0.in_valid = 1'b1; bus0.a = 8'd9; bus0.b = 8'd9; bus0.start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("t2_stall_res", 32'(bus0.res), 32);
         check("t2_stall_valid", 32'(bus0.res_valid), 1);
         check("t2_stall_in_ready", 32'(bus0.in_ready), 0);
         check("t2_stall_busy", 32'(bus0.busy), 1);
         step();
      end
      bus0.res_ready = 1'b1;
      step();
      bus0.start = 1'b0;
      check("t2_start_at_handoff_ignored", 32'(bus0.busy), 0);
      check("t2_res_after", 32'(bus0.res), 32);
      bus0.res_ready = 1'b0;

      // zero-length product
      bus0.start = 1'b1; bus0.k_len = 5'd0; bus0.in_valid = 1'b1;
      step();
      bus0.start = 1'b0;
      check("t3_res_valid", 32'(bus0.res_valid), 1);
      check("t3_res", 32'(bus0.res), 0);
      check("t3_in_ready", 32'(bus0.in_ready), 0);
      bus0.res_ready = 1'b1;
      step();
      bus0.in_valid = 1'b0;
      check("t3_idle", 32'(bus0.busy), 0);
      bus0.res_ready = 1'b0;

      // k_len 20 clamps to 16 beats of 1*1
      bus0.start = 1'b1; bus0.k_len = 5'd20;
      step();
      bus0.start = 1'b0;
      bus0.in_valid = 1'b1; bus0.a = 8'd1; bus0.b = 8'd1;
      n = 0;
      while (!bus0.res_valid && n < 40) begin
         step();
         n++;
      end
      bus0.in_valid = 1'b0;
      check("clamp_res_valid", 32'(bus0.res_valid), 1);
      check("clamp_beats", 32'(n), 16);
      check("clamp_res", 32'(bus0.res), 16);
      bus0.res_ready = 1'b1;
      step();
      bus0.res_ready = 1'b0;

      // 16-bit accumulator overflow: 255*255 twice
      bus1.start = 1'b1; bus1.k_len = 5'd2;
      step();
      bus1.start = 1'b0;
      bus1.in_valid = 1'b1; bus1.a = 8'd255; bus1.b = 8'd255;
      step();
      step();
      bus1.in_valid = 1'b0;
      check("t4_res_valid", 32'(bus1.res_valid), 1);
`ifdef MAC_THREAD_SAT_EN
      check("t4_res", 32'(bus1.res), 65535);
      check("t4_sat", 32'(bus1.sat), 1);
`else
      check("t4_res", 32'(bus1.res), 64514);
      check("t4_sat", 32'(bus1.sat), 0);
`endif
      bus1.res_ready = 1'b1;
      step();
      bus1.start = 1'b1; bus1.k_len = 5'd1;
      step();
      bus1.start = 1'b0;
      check("t4_sat_cleared", 32'(bus1.sat), 0);
      bus1.in_valid = 1'b1; bus1.a = 8'd1; bus1.b = 8'd1;
      step();
      bus1.in_valid = 1'b0;
      check("t4_res2", 32'(bus1.res), 1);
      step();
      bus1.res_ready = 1'b0;

      // signed: (-3)*5 + 4*(-2) = -23
      bus2.start = 1'b1; bus2.k_len = 5'd2;
      step();
      bus2.start = 1'b0;
      bus2.in_valid = 1'b1; bus2.a = 8'hFD; bus2.b = 8'd5;
      step();
      bus2.a = 8'd4; bus2.b = 8'hFE;
      step();
      bus2.in_valid = 1'b0;
      check("t5_res_valid", 32'(bus2.res_valid), 1);
      check("t5_res", 32'(bus2.res), 32'h000F_FFE9);
      check("t5_sat", 32'(bus2.sat), 0);
      bus2.res_ready = 1'b1;
      step();
      bus2.res_ready = 1'b0;

      // reset part-way through a 4-beat product, then a fresh one
      bus0.start = 1'b1; bus0.k_len = 5'd4;
      step();
      bus0.start = 1'b0;
      bus0.in_valid = 1'b1; bus0.a = 8'd1; bus0.b = 8'd1;
      step();
      step();
      rst = 1'b0;
      #1;
      check("t6_rst_res", 32'(bus0.res), 0);
      check("t6_rst_valid", 32'(bus0.res_valid), 0);
      check("t6_rst_busy", 32'(bus0.busy), 0);
      check("t6_rst_in_ready", 32'(bus0.in_ready), 0);
      bus0.in_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      bus0.start = 1'b1; bus0.k_len = 5'd1;
      step();
      bus0.start = 1'b0;
      bus0.in_valid = 1'b1; bus0.a = 8'd7; bus0.b = 8'd6;
      step();
      bus0.in_valid = 1'b0;
      check("t6_res_valid", 32'(bus0.res_valid), 1);
      check("t6_res", 32'(bus0.res), 42);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
